pe_array_bist_engine: RTL

- Self-contained BIST engine for the systolic PE array's activation/weight propagation path.
- On `start`, drives NUM_PATTERNS pseudo-random pattern words onto the array's flat A/W input buses.
- Regenerates the same sequence LATENCY cycles later and compares it against the flat A/W output buses.
- Reports `bist_done`, `final_error` and a mismatch count; it is the responder that a benchmark bench launches with `start`.

---
 rtl/pe_array_bist_engine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pe_array_bist_engine.sv
// pe_array_bist_engine
//   Built-in self test for the systolic PE array's activation/weight
//   propagation path. On start, a 16-bit LFSR drives NUM_PATTERNS pattern
//   words onto the flat A/W input buses, one word per cycle. A second LFSR
//   with the same seed regenerates the sequence LATENCY cycles later and
//   checks it against the array's flat A/W output buses.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        run request (level), sampled in IDLE only
//   bist_done    run complete, held until start is low
//   final_error  sticky: at least one mismatching compare cycle
//   fail_count   saturating count of mismatching compare cycles
//   busy         high while driving or draining
//   array_in_a   flat activation drive, lane i at [i*A_WIDTH +: A_WIDTH]
//   array_in_w   flat weight drive, same lane packing
//   array_out_a  flat activation output from the array
//   array_out_w  flat weight output from the array
module pe_array_bist_engine #(
  parameter int          ARRAY_SIZE   = 16,
  parameter int          NUM_PATTERNS = 16,
  parameter int          A_WIDTH      = 8,
  parameter int          W_WIDTH      = 8,
  parameter int          LATENCY      = 16,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          bist_done,
  output logic                          final_error,
  output logic [7:0]                    fail_count,
  output logic                          busy,
  output logic [A_WIDTH*ARRAY_SIZE-1:0] array_in_a,
  output logic [W_WIDTH*ARRAY_SIZE-1:0] array_in_w,
  input  logic [A_WIDTH*ARRAY_SIZE-1:0] array_out_a,
  input  logic [W_WIDTH*ARRAY_SIZE-1:0] array_out_w
);

  localparam int AB = A_WIDTH * ARRAY_SIZE;
  localparam int WB = W_WIDTH * ARRAY_SIZE;
  localparam int CW = $clog2(LATENCY + NUM_PATTERNS + 1);

  // cyc holds (edges since DRIVE entry) - 1 when sampled at an edge, so the
  // edge that ends the k-th DRIVE cycle sees cyc == k - 1.
  localparam logic [CW-1:0] LAST_DRV  = CW'(NUM_PATTERNS - 1);
  localparam logic [CW-1:0] FIRST_CMP = CW'(LATENCY);
  localparam logic [CW-1:0] LAST_CMP  = CW'(LATENCY + NUM_PATTERNS - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   gen_lfsr;
  logic [15:0]   chk_lfsr;
  logic [CW-1:0] cyc;
  logic          in_cmp;
  logic          mismatch;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [AB-1:0] lanes_a(input logic [15:0] p);
    logic [AB-1:0] bus;
    bus = '0;
    for (int i = 0; i < ARRAY_SIZE; i++)
      bus[i*A_WIDTH +: A_WIDTH] = p[A_WIDTH-1:0] ^ A_WIDTH'(i);
    return bus;
  endfunction

  function automatic logic [WB-1:0] lanes_w(input logic [15:0] p);
    logic [WB-1:0] bus;
    bus = '0;
    for (int i = 0; i < ARRAY_SIZE; i++)
      bus[i*W_WIDTH +: W_WIDTH] = p[15 -: W_WIDTH] ^ ~W_WIDTH'(i);
    return bus;
  endfunction

  assign busy      = (state == DRIVE) || (state == DRAIN);
  assign bist_done = (state == DONE);

  // Compare window covers LATENCY+1 .. LATENCY+NUM_PATTERNS edges after
  // DRIVE entry; it may overlap DRIVE when LATENCY < NUM_PATTERNS.
  always_comb begin
    in_cmp    = busy && (cyc >= FIRST_CMP) && (cyc <= LAST_CMP);
    mismatch  = in_cmp && ((array_out_a != lanes_a(chk_lfsr)) ||
                           (array_out_w != lanes_w(chk_lfsr)));
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (cyc == LAST_DRV) state_nxt = DRAIN;
      DRAIN:   if (in_cmp && (cyc == LAST_CMP)) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gen_lfsr    <= SEED;
      chk_lfsr    <= SEED;
      cyc         <= '0;
      array_in_a  <= '0;
      array_in_w  <= '0;
      final_error <= 1'b0;
      fail_count  <= '0;
    end else begin
      state      <= state_nxt;
      array_in_a <= '0;
      array_in_w <= '0;

      // Launch: word 0 (the seed) goes out on the entry edge itself.
      if ((state == IDLE) && start) begin
        gen_lfsr    <= lfsr_next(SEED);
        chk_lfsr    <= SEED;
        cyc         <= '0;
        array_in_a  <= lanes_a(SEED);
        array_in_w  <= lanes_w(SEED);
        final_error <= 1'b0;
        fail_count  <= '0;
      end

      if (busy) cyc <= cyc + 1'b1;

      // Words 1..NUM_PATTERNS-1; the edge leaving DRIVE leaves the bus at 0.
      if ((state == DRIVE) && (cyc != LAST_DRV)) begin
        array_in_a <= lanes_a(gen_lfsr);
        array_in_w <= lanes_w(gen_lfsr);
        gen_lfsr   <= lfsr_next(gen_lfsr);
      end

      if (in_cmp) begin
        chk_lfsr <= lfsr_next(chk_lfsr);
        if (mismatch) begin
          final_error <= 1'b1;
          if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        end
      end
    end
  end

endmodule
